// File: rtl/bcd_counter_nd.sv
// N-digit BCD up/down counter with prescaler, clamped parallel load,
// wrap/saturate limit handling and registered per-digit 7-segment outputs.
module bcd_counter_nd #(
    parameter int DIGITS         = 4,
    parameter int DIV_MAX        = 50000000,
    parameter int USE_PRESCALER  = 1,
    parameter int SATURATE       = 0,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  iEn,
    input  logic                  iUp,
    input  logic                  iStep,
    input  logic                  iLoad,
    input  logic [4*DIGITS-1:0]   iLoadVal,
    output logic [4*DIGITS-1:0]   oBCD,
    output logic [7*DIGITS-1:0]   oSeg,
    output logic                  oWrap,
    output logic                  oAtLimit
);

    localparam int PW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;

    logic [PW-1:0] presc_r;
    logic [BW-1:0] bcd_r;
    logic [BW-1:0] bcd_next_s;
    logic [BW-1:0] load_clamped_s;
    logic [SW-1:0] seg_r;
    logic [SW-1:0] seg_next_s;
    logic          wrap_r;
    logic          wrap_next_s;
    logic          presc_tick_s;
    logic          tick_s;
    logic          all9_s;
    logic          all0_s;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return (SEG_ACTIVE_LOW != 0) ? ~p : p;
    endfunction

    // Free-running prescaler; iEn and iLoad never disturb its phase.
    always_ff @(posedge iclk) begin
        if (irst) begin
            presc_r <= '0;
        end else if (presc_r == PW'(DIV_MAX - 1)) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    assign presc_tick_s = (presc_r == PW'(DIV_MAX - 1));
    assign tick_s       = (USE_PRESCALER != 0) ? presc_tick_s : iStep;

    // Limit detection over the current count.
    always_comb begin
        all9_s = 1'b1;
        all0_s = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            all9_s = all9_s & (bcd_r[4*k +: 4] == 4'd9);
            all0_s = all0_s & (bcd_r[4*k +: 4] == 4'd0);
        end
    end

    // Load value with any non-decimal digit clamped to 9.
    always_comb begin
        load_clamped_s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            load_clamped_s[4*k +: 4] = (iLoadVal[4*k +: 4] > 4'd9) ? 4'd9 : iLoadVal[4*k +: 4];
        end
    end

    // Next count: load beats tick; carry/borrow ripples through all digits in one cycle.
    always_comb begin
        logic carry;
        bcd_next_s  = bcd_r;
        wrap_next_s = 1'b0;
        carry       = 1'b1;
        if (iLoad) begin
            bcd_next_s = load_clamped_s;
        end else if (tick_s && iEn) begin
            if (iUp && all9_s) begin
                wrap_next_s = 1'b1;
                bcd_next_s  = (SATURATE != 0) ? bcd_r : {BW{1'b0}};
            end else if (!iUp && all0_s) begin
                wrap_next_s = 1'b1;
                bcd_next_s  = (SATURATE != 0) ? bcd_r : {DIGITS{4'd9}};
            end else begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (!carry) begin
                        bcd_next_s[4*k +: 4] = bcd_r[4*k +: 4];
                    end else if (iUp) begin
                        if (bcd_r[4*k +: 4] == 4'd9) begin
                            bcd_next_s[4*k +: 4] = 4'd0;
                        end else begin
                            bcd_next_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd1;
                            carry                = 1'b0;
                        end
                    end else begin
                        if (bcd_r[4*k +: 4] == 4'd0) begin
                            bcd_next_s[4*k +: 4] = 4'd9;
                        end else begin
                            bcd_next_s[4*k +: 4] = bcd_r[4*k +: 4] - 4'd1;
                            carry                = 1'b0;
                        end
                    end
                end
            end
        end else begin
            bcd_next_s = bcd_r;
        end
    end

    // Segment patterns for the current count, registered below for one-cycle latency.
    always_comb begin
        seg_next_s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            seg_next_s[7*k +: 7] = seg_decode(bcd_r[4*k +: 4]);
        end
    end

    // Count, wrap pulse and segment registers.
    always_ff @(posedge iclk) begin
        if (irst) begin
            bcd_r  <= '0;
            wrap_r <= 1'b0;
            seg_r  <= {DIGITS{seg_decode(4'd0)}};
        end else begin
            bcd_r  <= bcd_next_s;
            wrap_r <= wrap_next_s;
            seg_r  <= seg_next_s;
        end
    end

    assign oBCD     = bcd_r;
    assign oSeg     = seg_r;
    assign oWrap    = wrap_r;
    assign oAtLimit = iUp ? all9_s : all0_s;

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Directed bench: instance A uses the prescaler (DIV_MAX=4, wrap mode),
// instance B uses iStep as the tick with saturation enabled.
module tb_bcd_counter_nd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_en, a_up, a_step, a_load, a_wrap, a_atl;
    logic [15:0] a_lv, a_bcd;
    logic [27:0] a_seg;
    logic        b_rst, b_en, b_up, b_step, b_load, b_wrap, b_atl;
    logic [15:0] b_lv, b_bcd;
    logic [27:0] b_seg;

    int errors = 0;
    int checks = 0;

    bcd_counter_nd #(.DIGITS(4), .DIV_MAX(4), .USE_PRESCALER(1), .SATURATE(0), .SEG_ACTIVE_LOW(1)) dut_a (
        .iclk(clk), .irst(a_rst), .iEn(a_en), .iUp(a_up), .iStep(a_step), .iLoad(a_load),
        .iLoadVal(a_lv), .oBCD(a_bcd), .oSeg(a_seg), .oWrap(a_wrap), .oAtLimit(a_atl));

    bcd_counter_nd #(.DIGITS(4), .DIV_MAX(4), .USE_PRESCALER(0), .SATURATE(1), .SEG_ACTIVE_LOW(1)) dut_b (
        .iclk(clk), .irst(b_rst), .iEn(b_en), .iUp(b_up), .iStep(b_step), .iLoad(b_load),
        .iLoadVal(b_lv), .oBCD(b_bcd), .oSeg(b_seg), .oWrap(b_wrap), .oAtLimit(b_atl));

    typedef struct {
        logic        load;
        logic [15:0] lv;
        logic        en;
        logic        up;
        logic        step;
        logic [15:0] bcd;
        logic        wrap;
        logic        atl;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [6:0] seg_model(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0: p = 7'h3F; 4'd1: p = 7'h06; 4'd2: p = 7'h5B; 4'd3: p = 7'h4F;
            4'd4: p = 7'h66; 4'd5: p = 7'h6D; 4'd6: p = 7'h7D; 4'd7: p = 7'h07;
            4'd8: p = 7'h7F; 4'd9: p = 7'h6F;
            default: p = 7'h00;
        endcase
        return ~p;
    endfunction

    function automatic logic [27:0] seg4(input logic [15:0] b);
        logic [27:0] r;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = seg_model(b[4*i +: 4]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    // Waits for instance A's count to leave prev; an expired bound is a failure.
    task automatic wait_change(input logic [15:0] prev, input int bound);
        int n;
        n = 0;
        do begin
            tick_edge();
            n++;
        end while (a_bcd == prev && n < bound);
        checks++;
        if (a_bcd == prev) begin
            errors++;
            $display("FAIL wait_tick: count stuck at %h after %0d clocks", a_bcd, n);
        end
    endtask

    initial begin
        logic [15:0] prev_exp;

        tbl[0]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0099, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 16'h9998, 1'b1, 1'b1, 1'b0, 16'h9998, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h9999, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 16'hA3F5, 1'b1, 1'b1, 1'b0, 16'h9395, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1235, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};

        a_rst = 1'b1; a_en = 1'b1; a_up = 1'b1; a_step = 1'b0; a_load = 1'b0; a_lv = 16'h0000;
        b_rst = 1'b1; b_en = 1'b1; b_up = 1'b1; b_step = 1'b0; b_load = 1'b0; b_lv = 16'h0000;
        repeat (2) tick_edge();
        chk("reset_a_bcd", a_bcd, 16'h0000);
        chk("reset_a_seg", a_seg, 28'h8102040);
        chk("reset_a_wrap", a_wrap, 1'b0);
        chk("reset_b_bcd", b_bcd, 16'h0000);
        chk("reset_b_seg", b_seg, 28'h8102040);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // First prescaled tick lands on the 4th edge after release.
        for (int i = 0; i < 3; i++) begin
            tick_edge();
            chk("a_prescale_hold", a_bcd, 16'h0000);
        end
        tick_edge();
        chk("a_first_inc", a_bcd, 16'h0001);
        chk("a_seg_lag", a_seg, seg4(16'h0000));
        tick_edge();
        chk("a_seg_follow", a_seg, seg4(16'h0001));

        // Up wrap through 9999.
        a_load = 1'b1; a_lv = 16'h9998;
        tick_edge();
        a_load = 1'b0;
        chk("a_load_9998", a_bcd, 16'h9998);
        chk("a_load_nowrap", a_wrap, 1'b0);
        wait_change(16'h9998, 6);
        chk("a_reach_9999", a_bcd, 16'h9999);
        chk("a_atlimit_9999", a_atl, 1'b1);
        chk("a_nowrap_9999", a_wrap, 1'b0);
        wait_change(16'h9999, 6);
        chk("a_wrap_to_0", a_bcd, 16'h0000);
        chk("a_wrap_pulse", a_wrap, 1'b1);
        tick_edge();
        chk("a_wrap_one_clk", a_wrap, 1'b0);
        chk("a_atlimit_0_up", a_atl, 1'b0);

        // Reset mid-count with the prescaler at 2.
        a_load = 1'b1; a_lv = 16'h0456;
        tick_edge();
        a_load = 1'b0;
        wait_change(16'h0456, 6);
        chk("a_reach_0457", a_bcd, 16'h0457);
        repeat (2) begin
            tick_edge();
            chk("a_hold_0457", a_bcd, 16'h0457);
        end
        a_rst = 1'b1;
        tick_edge();
        chk("a_midreset_bcd", a_bcd, 16'h0000);
        chk("a_midreset_wrap", a_wrap, 1'b0);
        a_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_edge();
            chk("a_post_reset_hold", a_bcd, 16'h0000);
        end
        tick_edge();
        chk("a_post_reset_inc", a_bcd, 16'h0001);
        a_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick_edge();
            chk("a_disabled_hold", a_bcd, 16'h0001);
        end

        // Step-driven table on instance B.
        prev_exp = 16'h0000;
        for (int i = 0; i < 17; i++) begin
            b_load = tbl[i].load; b_lv = tbl[i].lv; b_en = tbl[i].en;
            b_up = tbl[i].up; b_step = tbl[i].step;
            tick_edge();
            chk($sformatf("b_bcd[%0d]", i), b_bcd, tbl[i].bcd);
            chk($sformatf("b_wrap[%0d]", i), b_wrap, tbl[i].wrap);
            chk($sformatf("b_atl[%0d]", i), b_atl, tbl[i].atl);
            chk($sformatf("b_seg[%0d]", i), b_seg, seg4(prev_exp));
            prev_exp = tbl[i].bcd;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
